// File: rtl/fire_sched_pkg.sv
// Shared types and constants for the fire scheduler: FSM states, selection
// modes, LFSR taps and the fire-index width helper.
package fire_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DEADLOCK = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int MODE_RR   = 0;
  localparam int MODE_LFSR = 1;

  // Galois form of x^16 + x^14 + x^13 + x^11, shifting right.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fire_sched_pick.sv
// Rotating priority encoder: first set bit of i_excited at or after i_start,
// wrapping past the top. o_index is N when nothing is set.
module fire_sched_pick
  import fire_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic [N-1:0] i_excited,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_index,
  output logic         o_found
);

  logic [N-1:0] w_rot;
  logic [W-1:0] w_pos;
  logic [W:0]   w_sum;

  // Rotate so that bit 0 of w_rot corresponds to transition i_start.
  assign w_rot = N'({i_excited, i_excited} >> i_start);

  // Lowest set bit of the rotated vector.
  always_comb begin
    w_pos = W'(0);
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_pos = W'(j);
      end else begin
        w_pos = w_pos;
      end
    end
  end

  assign w_sum = {1'b0, i_start} + {1'b0, w_pos};

  // Map the rotated position back to an absolute index.
  always_comb begin
    o_found = |w_rot;
    if (!o_found) begin
      o_index = W'(N);
    end else if (w_sum >= (W+1)'(N)) begin
      o_index = W'(w_sum - (W+1)'(N));
    end else begin
      o_index = w_sum[W-1:0];
    end
  end

endmodule

// File: rtl/fire_scheduler.sv
// Picks one excited transition per clock for the circuit model (round-robin or
// LFSR start), counts fires, flags deadlock and budget exhaustion.
// Optional hazard monitor enabled by FIRE_SCHED_PERSIST_CHECK_EN.
module fire_scheduler
  import fire_sched_pkg::*;
#(
  parameter int          N_TRANSITIONS   = 8,
  parameter int          MODE            = 0,
  parameter logic [15:0] SEED            = 16'hACE1,
  parameter int          MAX_FIRES       = 0,
  parameter int          DEADLOCK_CYCLES = 16,
  parameter int          CNT_W           = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                run,
  input  logic [N_TRANSITIONS-1:0]            excited,
  output logic [idx_width(N_TRANSITIONS)-1:0] fire,
  output logic                                fire_valid,
  output logic [CNT_W-1:0]                    fire_count,
  output logic                                deadlock,
  output logic                                done
`ifdef FIRE_SCHED_PERSIST_CHECK_EN
  ,
  output logic                                persist_err,
  output logic [idx_width(N_TRANSITIONS)-1:0] persist_idx
`endif
);

  localparam int W  = idx_width(N_TRANSITIONS);
  localparam int SW = $clog2(DEADLOCK_CYCLES + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [W-1:0]     r_ptr;
  logic [15:0]      r_lfsr;
  logic [SW-1:0]    r_stall;
  logic [CNT_W-1:0] r_fire_count;
  logic             r_deadlock;
  logic             r_done;

  logic             w_active;
  logic             w_no_exc;
  logic [W-1:0]     w_lfsr_low;
  logic [W-1:0]     w_start;
  logic [W-1:0]     w_pick_idx;
  logic             w_pick_found;
  logic [W-1:0]     w_ptr_nxt;
  logic [15:0]      w_lfsr_nxt;
  logic [SW:0]      w_stall_inc;
  logic             w_stall_hit;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_budget_hit;

  assign w_active   = (r_state == RUN) && run;
  assign w_no_exc   = ~|excited;
  assign w_lfsr_low = r_lfsr[W-1:0];

  // Search start: rotating pointer, or the folded low LFSR bits.
  always_comb begin
    if (MODE == MODE_LFSR) begin
      if (w_lfsr_low >= W'(N_TRANSITIONS)) begin
        w_start = w_lfsr_low - W'(N_TRANSITIONS);
      end else begin
        w_start = w_lfsr_low;
      end
    end else begin
      w_start = r_ptr;
    end
  end

  fire_sched_pick #(
    .N (N_TRANSITIONS),
    .W (W)
  ) u_pick (
    .i_excited (excited),
    .i_start   (w_start),
    .o_index   (w_pick_idx),
    .o_found   (w_pick_found)
  );

  // Zero-latency select: the circuit consumes fire on the same edge.
  always_comb begin
    if (w_active && w_pick_found) begin
      fire_valid = 1'b1;
      fire       = w_pick_idx;
    end else begin
      fire_valid = 1'b0;
      fire       = W'(N_TRANSITIONS);
    end
  end

  assign w_ptr_nxt    = (w_pick_idx == W'(N_TRANSITIONS - 1)) ? W'(0) : w_pick_idx + W'(1);
  assign w_lfsr_nxt   = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
  assign w_stall_inc  = {1'b0, r_stall} + (SW+1)'(1);
  assign w_stall_hit  = w_active && w_no_exc && (w_stall_inc == (SW+1)'(DEADLOCK_CYCLES));
  assign w_cnt_nxt    = (&r_fire_count) ? r_fire_count : r_fire_count + CNT_W'(1);
  assign w_budget_hit = (MAX_FIRES != 0) && fire_valid &&
                        (({1'b0, r_fire_count} + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_FIRES));

  // Next-state logic; budget exhaustion takes precedence over deadlock.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (run) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_budget_hit) begin
          w_state_nxt = DONE;
        end else if (w_stall_hit) begin
          w_state_nxt = DEADLOCK;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DEADLOCK: w_state_nxt = DEADLOCK;
      DONE:     w_state_nxt = DONE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // State register plus the pointer, LFSR, stall and fire counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ptr        <= W'(0);
      r_lfsr       <= SEED;
      r_stall      <= SW'(0);
      r_fire_count <= CNT_W'(0);
      r_deadlock   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_deadlock <= r_deadlock | (w_state_nxt == DEADLOCK);
      r_done     <= r_done | (w_state_nxt == DONE);
      if (w_active) begin
        r_lfsr  <= w_lfsr_nxt;
        r_stall <= w_no_exc ? w_stall_inc[SW-1:0] : SW'(0);
        if (fire_valid) begin
          r_ptr        <= w_ptr_nxt;
          r_fire_count <= w_cnt_nxt;
        end else begin
          r_ptr        <= r_ptr;
          r_fire_count <= r_fire_count;
        end
      end else begin
        r_lfsr  <= r_lfsr;
        r_stall <= r_stall;
      end
    end
  end

  assign fire_count = r_fire_count;
  assign deadlock   = r_deadlock;
  assign done       = r_done;

`ifdef FIRE_SCHED_PERSIST_CHECK_EN
  logic [N_TRANSITIONS-1:0] r_pend;
  logic                     r_pend_vld;
  logic                     r_persist_err;
  logic [W-1:0]             r_persist_idx;
  logic [N_TRANSITIONS-1:0] w_fired_oh;
  logic [N_TRANSITIONS-1:0] w_viol;
  logic [W-1:0]             w_viol_idx;

  // A transition left pending last running cycle must still be excited now.
  always_comb begin
    w_fired_oh = fire_valid ? ({{(N_TRANSITIONS-1){1'b0}}, 1'b1} << w_pick_idx)
                            : {N_TRANSITIONS{1'b0}};
    if (r_pend_vld && w_active) begin
      w_viol = r_pend & ~excited;
    end else begin
      w_viol = {N_TRANSITIONS{1'b0}};
    end
    w_viol_idx = W'(N_TRANSITIONS);
    for (int j = N_TRANSITIONS - 1; j >= 0; j--) begin
      if (w_viol[j]) begin
        w_viol_idx = W'(j);
      end else begin
        w_viol_idx = w_viol_idx;
      end
    end
  end

  // Pending-set snapshot and first-violation capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend        <= {N_TRANSITIONS{1'b0}};
      r_pend_vld    <= 1'b0;
      r_persist_err <= 1'b0;
      r_persist_idx <= W'(N_TRANSITIONS);
    end else begin
      if (w_active) begin
        r_pend     <= excited & ~w_fired_oh;
        r_pend_vld <= 1'b1;
      end else begin
        r_pend     <= r_pend;
        r_pend_vld <= r_pend_vld;
      end
      if (!r_persist_err && (|w_viol)) begin
        r_persist_err <= 1'b1;
        r_persist_idx <= w_viol_idx;
      end else begin
        r_persist_err <= r_persist_err;
        r_persist_idx <= r_persist_idx;
      end
    end
  end

  assign persist_err = r_persist_err;
  assign persist_idx = r_persist_idx;
`endif

endmodule
